mult_sequencer: RTL and testbench

Sequencing controller for the pipeline's multi-cycle multiplier. It accepts multiply instructions as they leave decode and issues a one-cycle start pulse to the multiplier in the execute stage. It tracks the fixed multiplier latency, raises the HI/LO capture strobe when the product is valid, and requests a decode stall for structural or HI/LO data hazards. It sits beside the hazard detector; its stall output is ORed into stallF/stallD/flushE by the hazard logic.

---
 rtl/mult_sequencer.sv | 99 +++++++++
 tb/tb_mult_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Purpose: issues start pulses to the multi-cycle multiplier, strobes HI/LO capture, flags decode stalls.
// Latency: start_mult one cycle after issue; hilo_we LATENCY cycles after issue; stall_mult combinational.
// Backpressure: requests a stall while busy; an issue waits for stallD_ext and flushE to be low.
module mult_sequencer #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_multD,
  input  logic              mult_signD,
  input  logic [1:0]        out_selectD,
  input  logic              stallD_ext,
  input  logic              flushE,
  output logic              start_mult,
  output logic              mult_sign,
  output logic              hilo_we,
  output logic              busy,
  output logic              stall_mult,
  output logic [PERF_W-1:0] mult_count,
  output logic [PERF_W-1:0] stall_count
);

  typedef enum logic {IDLE, RUN} state_t;

  // Countdown starts at LATENCY-1 so the product lands exactly LATENCY cycles after issue.
  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             ready;
  logic             mfRead;
  logic             issue;

  // Readiness, hazard detection and next-state selection.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    ready      = (state == IDLE) || (cnt == '0);
    mfRead     = out_selectD[1];
    issue      = start_multD && ready && !stallD_ext && !flushE;
    stall_mult = !ready && (start_multD || mfRead);
    hilo_we    = (state == RUN) && (cnt == '0);
    busy       = (state == RUN);
    if (issue) begin
      stateNext = RUN;
      cntNext   = CntLoad;
    end else if (state == RUN) begin
      if (cnt != '0) begin
        cntNext = cnt - CNT_W'(1);
      end else begin
        stateNext = IDLE;
      end
    end
  end

  // State and latency counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Start pulse and sign mode, both launched by an issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_mult <= 1'b0;
      mult_sign  <= 1'b0;
    end else begin
      start_mult <= issue;
      if (issue) begin
        mult_sign <= mult_signD;
      end
    end
  end

  // Saturating performance counters: completed multiplies and stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_count  <= '0;
      stall_count <= '0;
    end else begin
      if (hilo_we && (mult_count != '1)) begin
        mult_count <= mult_count + PERF_W'(1);
      end
      if (stall_mult && (stall_count != '1)) begin
        stall_count <= stall_count + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Purpose: exercises mult_sequencer with directed scenarios and random traffic against a cycle model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: stallD_ext and flushE are driven randomly and in directed bursts.
module tb_mult_sequencer;

  localparam int LAT    = 4;
  localparam int PW     = 4;
  localparam int SATMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_multD;
  logic          mult_signD;
  logic [1:0]    out_selectD;
  logic          stallD_ext;
  logic          flushE;
  logic          start_mult;
  logic          mult_sign;
  logic          hilo_we;
  logic          busy;
  logic          stall_mult;
  logic [PW-1:0] mult_count;
  logic [PW-1:0] stall_count;

  mult_sequencer #(.LATENCY(LAT), .CNT_W(4), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .start_multD(start_multD), .mult_signD(mult_signD),
    .out_selectD(out_selectD), .stallD_ext(stallD_ext), .flushE(flushE),
    .start_mult(start_mult), .mult_sign(mult_sign), .hilo_we(hilo_we), .busy(busy),
    .stall_mult(stall_mult), .mult_count(mult_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  // Model: cycle index of the pending product (-1 = none), previous-cycle issue, sign, counts.
  int cyc;
  int lastWe;
  bit issuedPrev;
  bit mSign;
  int mCnt;
  int sCnt;

  // Outputs sampled in the most recent step, for literal checks.
  logic sStart, sBusy, sHilo, sStall;

  task automatic chk(input string nm, input int act, input int exp);
    nVec++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [3:0] e);
    chk(nm, int'({sStart, sBusy, sHilo, sStall}), int'(e));
  endtask

  task automatic modelInit();
    cyc        = 0;
    lastWe     = -1;
    issuedPrev = 0;
    mSign      = 0;
    mCnt       = 0;
    sCnt       = 0;
  endtask

  task automatic idleInputs();
    start_multD = 0; mult_signD = 0; out_selectD = 2'b00; stallD_ext = 0; flushE = 0;
  endtask

  // Synchronous-window reset: outputs must read zero while reset is held.
  task automatic doReset();
    reset = 1;
    idleInputs();
    @(negedge clk);
    chk("rst_outs", int'({start_mult, mult_sign, hilo_we, busy, stall_mult}), 0);
    chk("rst_mcnt", int'(mult_count), 0);
    chk("rst_scnt", int'(stall_count), 0);
    @(posedge clk);
    #1;
    reset = 0;
    modelInit();
  endtask

  // One pipeline cycle: apply decode inputs, compare against the model, advance the model.
  task automatic step(input logic sd, input logic sg, input logic [1:0] os,
                      input logic se, input logic fl);
    bit pending, rdy, eHilo, eStall, iss;
    start_multD = sd; mult_signD = sg; out_selectD = os; stallD_ext = se; flushE = fl;
    @(negedge clk);
    pending = (lastWe >= cyc);
    rdy     = !pending || (lastWe == cyc);
    eHilo   = pending && (lastWe == cyc);
    eStall  = !rdy && (sd || os[1]);
    iss     = sd && rdy && !se && !fl;
    sStart = start_mult; sBusy = busy; sHilo = hilo_we; sStall = stall_mult;
    chk("start_mult", int'(start_mult), int'(issuedPrev));
    chk("busy", int'(busy), int'(pending));
    chk("hilo_we", int'(hilo_we), int'(eHilo));
    chk("stall_mult", int'(stall_mult), int'(eStall));
    chk("mult_sign", int'(mult_sign), int'(mSign));
    chk("mult_count", int'(mult_count), mCnt);
    chk("stall_count", int'(stall_count), sCnt);
    if (eHilo && mCnt < SATMAX) mCnt++;
    if (eStall && sCnt < SATMAX) sCnt++;
    if (iss) begin
      lastWe = cyc + LAT;
      mSign  = sg;
    end
    issuedPrev = iss;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    reset = 1;
    idleInputs();
    modelInit();
    #1;
    doReset();

    // Single signed multiply.
    step(1, 1, 2'b00, 0, 0); lit("one_c0", 4'b0000);
    step(0, 0, 2'b00, 0, 0); lit("one_c1", 4'b1100);
    step(0, 0, 2'b00, 0, 0); lit("one_c2", 4'b0100);
    step(0, 0, 2'b00, 0, 0); lit("one_c3", 4'b0100);
    step(0, 0, 2'b00, 0, 0); lit("one_c4", 4'b0110);
    step(0, 0, 2'b00, 0, 0); lit("one_c5", 4'b0000);
    chk("one_mcnt", int'(mult_count), 1);
    chk("one_sign", int'(mult_sign), 1);

    // mflo following a multiply.
    doReset();
    step(1, 0, 2'b00, 0, 0);
    step(0, 0, 2'b11, 0, 0); lit("mf_c1", 4'b1101);
    step(0, 0, 2'b11, 0, 0); lit("mf_c2", 4'b0101);
    step(0, 0, 2'b11, 0, 0); lit("mf_c3", 4'b0101);
    step(0, 0, 2'b11, 0, 0); lit("mf_c4", 4'b0110);
    step(0, 0, 2'b00, 0, 0);
    chk("mf_scnt", int'(stall_count), 3);

    // Two consecutive multiplies.
    doReset();
    step(1, 0, 2'b00, 0, 0);
    step(1, 1, 2'b00, 0, 0); lit("b2b_c1", 4'b1101);
    step(1, 1, 2'b00, 0, 0); lit("b2b_c2", 4'b0101);
    step(1, 1, 2'b00, 0, 0); lit("b2b_c3", 4'b0101);
    step(1, 1, 2'b00, 0, 0); lit("b2b_c4", 4'b0110);
    step(0, 0, 2'b00, 0, 0); lit("b2b_c5", 4'b1100);
    step(0, 0, 2'b00, 0, 0); lit("b2b_c6", 4'b0100);
    step(0, 0, 2'b00, 0, 0); lit("b2b_c7", 4'b0100);
    step(0, 0, 2'b00, 0, 0); lit("b2b_c8", 4'b0110);
    step(0, 0, 2'b00, 0, 0); lit("b2b_c9", 4'b0000);
    chk("b2b_mcnt", int'(mult_count), 2);
    chk("b2b_sign", int'(mult_sign), 1);

    // Issue deferred by an external decode stall, then squashed by flushE.
    doReset();
    step(1, 1, 2'b00, 1, 0); lit("ext_c0", 4'b0000);
    step(1, 1, 2'b00, 1, 0); lit("ext_c1", 4'b0000);
    step(1, 1, 2'b00, 0, 0); lit("ext_c2", 4'b0000);
    step(0, 0, 2'b00, 0, 0); lit("ext_c3", 4'b1100);
    quiet(4);
    step(1, 0, 2'b00, 0, 1); lit("fl_c0", 4'b0000);
    step(1, 0, 2'b00, 0, 1); lit("fl_c1", 4'b0000);
    step(0, 0, 2'b00, 0, 0); lit("fl_c2", 4'b0000);
    step(0, 0, 2'b00, 0, 0); lit("fl_c3", 4'b0000);

    // Asynchronous reset in cycle 2 of a multiply.
    doReset();
    step(1, 0, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    start_multD = 1;
    #1;
    chk("ar_pre_stall", int'(stall_mult), 1);
    chk("ar_pre_busy", int'(busy), 1);
    reset = 1;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_start", int'(start_mult), 0);
    chk("ar_stall", int'(stall_mult), 0);
    idleInputs();
    @(posedge clk);
    #1;
    reset = 0;
    modelInit();
    quiet(6);
    chk("ar_mcnt", int'(mult_count), 0);

    // Saturation: 17 completed multiplies with a 4-bit counter.
    doReset();
    for (int i = 0; i < 65; i++) step(1, 0, 2'b00, 0, 0);
    quiet(5);
    chk("sat_mcnt", int'(mult_count), 15);
    chk("sat_scnt", int'(stall_count), 15);

    // Random traffic with occasional resets.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        doReset();
      end else begin
        step($urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
